// File: rtl/rucksack_rom_loader_if.sv
// Byte-stream handshake carrying the raw rucksack puzzle text into the loader.
// The master drives bytes; the slave (the loader) returns ready.
interface rucksack_rom_loader_if;
  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/rucksack_rom_loader.sv
// Converts the ASCII rucksack listing into priority codes and writes the
// zero-terminated line image (plus one extra closing zero) into item memory.
module rucksack_rom_loader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  rucksack_rom_loader_if.slave   s_in,
  output logic                   o_mem_we,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic [DATA_W-1:0]      o_mem_wdata,
  output logic                   o_done,
  output logic [15:0]            o_line_count,
  output logic                   o_err_odd,
  output logic                   o_err_char,
  output logic                   o_err_overflow
);

  typedef enum logic [1:0] {
    ST_LOAD       = 2'd0,
    ST_FLUSH_LINE = 2'd1,
    ST_FLUSH_END  = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  localparam int                DEPTH        = 1 << ADDR_W;
  localparam int                LEN_W        = ADDR_W + 1;
  // Letters stop two slots early so the line-end and image-end zeros always fit.
  localparam logic [ADDR_W-1:0] LETTER_MAX   = ADDR_W'(DEPTH - 3);
  localparam logic [ADDR_W-1:0] LINE_END_MAX = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ZERO     = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE      = LEN_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_wptr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    w_len_nxt;
  logic                r_mem_we;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic [15:0]         r_line_count;
  logic                r_err_odd;
  logic                r_err_char;
  logic                r_err_overflow;
  logic                w_line_end;
  logic                w_set_char;
  logic                w_set_ovf;
  logic                w_in_ready;
  logic                w_xfer;
  logic                w_is_lower;
  logic                w_is_upper;
  logic [5:0]          w_code;
  logic [DATA_W-1:0]   w_letter_data;
  logic [7:0]          w_byte;

  assign w_in_ready    = (r_state == ST_LOAD) && !i_rst;
  assign w_xfer        = s_in.valid && w_in_ready;
  assign w_byte        = s_in.data;
  assign w_letter_data = {{(DATA_W-6){1'b0}}, w_code};
  assign s_in.ready    = w_in_ready;

  // Classify the presented byte and derive its priority code.
  always_comb begin
    w_is_lower = (w_byte >= 8'h61) && (w_byte <= 8'h7A);
    w_is_upper = (w_byte >= 8'h41) && (w_byte <= 8'h5A);
    if (w_is_lower) begin
      w_code = 6'(w_byte - 8'h60);
    end else if (w_is_upper) begin
      w_code = 6'(w_byte - 8'h26);
    end else begin
      w_code = 6'd0;
    end
  end

  // Next-state and write-request decode for the loader FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_we_nxt    = 1'b0;
    w_wdata_nxt = {DATA_W{1'b0}};
    w_line_end  = 1'b0;
    w_set_char  = 1'b0;
    w_set_ovf   = 1'b0;
    w_done_nxt  = r_done;
    case (r_state)
      ST_LOAD: begin
        if (w_xfer) begin
          if (w_is_lower || w_is_upper) begin
            if (r_wptr <= LETTER_MAX) begin
              w_we_nxt    = 1'b1;
              w_wdata_nxt = w_letter_data;
              w_len_nxt   = r_len + LEN_ONE;
            end else begin
              w_set_ovf = 1'b1;
            end
          end else if (w_byte == 8'h0A) begin
            if (r_len != LEN_ZERO) begin
              w_line_end = 1'b1;
              w_len_nxt  = LEN_ZERO;
              w_we_nxt   = (r_wptr <= LINE_END_MAX);
            end else begin
              w_len_nxt = LEN_ZERO;
            end
          end else if (w_byte == 8'h0D) begin
            w_set_char = 1'b0;
          end else begin
            w_set_char = 1'b1;
          end
          // An unterminated final line still needs its own zero before the image end.
          if (s_in.last) begin
            w_state_nxt = (w_len_nxt != LEN_ZERO) ? ST_FLUSH_LINE : ST_FLUSH_END;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_FLUSH_LINE: begin
        w_line_end  = 1'b1;
        w_len_nxt   = LEN_ZERO;
        w_we_nxt    = (r_wptr <= LINE_END_MAX);
        w_state_nxt = ST_FLUSH_END;
      end
      ST_FLUSH_END: begin
        w_we_nxt    = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write port, pointer, line length, counters and sticky flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr         <= {ADDR_W{1'b0}};
      r_len          <= LEN_ZERO;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= {ADDR_W{1'b0}};
      r_mem_wdata    <= {DATA_W{1'b0}};
      r_done         <= 1'b0;
      r_line_count   <= 16'h0000;
      r_err_odd      <= 1'b0;
      r_err_char     <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_len          <= w_len_nxt;
      r_mem_we       <= w_we_nxt;
      r_done         <= w_done_nxt;
      r_err_char     <= r_err_char | w_set_char;
      r_err_overflow <= r_err_overflow | w_set_ovf;
      if (w_we_nxt) begin
        r_mem_addr  <= r_wptr;
        r_mem_wdata <= w_wdata_nxt;
        r_wptr      <= r_wptr + ADDR_ONE;
      end else begin
        r_mem_addr  <= r_mem_addr;
        r_mem_wdata <= r_mem_wdata;
        r_wptr      <= r_wptr;
      end
      if (w_line_end) begin
        if (r_line_count != 16'hFFFF) begin
          r_line_count <= r_line_count + 16'd1;
        end else begin
          r_line_count <= r_line_count;
        end
        r_err_odd <= r_err_odd | r_len[0];
      end else begin
        r_line_count <= r_line_count;
        r_err_odd    <= r_err_odd;
      end
    end
  end

  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_done         = r_done;
  assign o_line_count   = r_line_count;
  assign o_err_odd      = r_err_odd;
  assign o_err_char     = r_err_char;
  assign o_err_overflow = r_err_overflow;

endmodule

// File: tb/tb_rucksack_rom_loader.sv
// Bench for rucksack_rom_loader: a full-size and a depth-8 instance, each
// checked against a trace-level model of the expected memory image.
module tb_rucksack_rom_loader;
  typedef struct { int addr; int data; } wr_t;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rucksack_rom_loader_if bus_a();
  rucksack_rom_loader_if bus_b();

  logic        we_a, done_a, eo_a, ec_a, ev_a;
  logic [13:0] addr_a;
  logic [7:0]  wd_a;
  logic [15:0] lc_a;
  logic        we_b, done_b, eo_b, ec_b, ev_b;
  logic [2:0]  addr_b;
  logic [7:0]  wd_b;
  logic [15:0] lc_b;

  rucksack_rom_loader #(.ADDR_W(14), .DATA_W(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .s_in(bus_a.slave),
    .o_mem_we(we_a), .o_mem_addr(addr_a), .o_mem_wdata(wd_a), .o_done(done_a),
    .o_line_count(lc_a), .o_err_odd(eo_a), .o_err_char(ec_a), .o_err_overflow(ev_a));

  rucksack_rom_loader #(.ADDR_W(3), .DATA_W(8)) dut_b (
    .i_clk(clk), .i_rst(rst), .s_in(bus_b.slave),
    .o_mem_we(we_b), .o_mem_addr(addr_b), .o_mem_wdata(wd_b), .o_done(done_b),
    .o_line_count(lc_b), .o_err_odd(eo_b), .o_err_char(ec_b), .o_err_overflow(ev_b));

  wr_t        expq_a[$];
  wr_t        expq_b[$];
  wr_t        ea, eb;
  logic [7:0] img_a[int];
  logic [7:0] img_b[int];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every write pulse must match the next expected (addr, data) of the model.
  always @(negedge clk) begin
    if (we_a) begin
      if (expq_a.size() == 0) chk("unexpected_write_a", int'(addr_a), -1);
      else begin
        ea = expq_a.pop_front();
        chk("waddr_a", int'(addr_a), ea.addr);
        chk("wdata_a", int'(wd_a), ea.data);
      end
      img_a[int'(addr_a)] = wd_a;
    end
    if (we_b) begin
      if (expq_b.size() == 0) chk("unexpected_write_b", int'(addr_b), -1);
      else begin
        eb = expq_b.pop_front();
        chk("waddr_b", int'(addr_b), eb.addr);
        chk("wdata_b", int'(wd_b), eb.data);
      end
      img_b[int'(addr_b)] = wd_b;
    end
  end

  function automatic int st(int sel, int k);
    if (sel == 0) begin
      case (k)
        0: return int'(done_a);  1: return int'(lc_a);   2: return int'(eo_a);
        3: return int'(ec_a);    4: return int'(ev_a);   5: return int'(bus_a.ready);
        6: return expq_a.size(); 7: return int'(we_a);   8: return int'(addr_a);
        9: return int'(wd_a);    default: return -1;
      endcase
    end else begin
      case (k)
        0: return int'(done_b);  1: return int'(lc_b);   2: return int'(eo_b);
        3: return int'(ec_b);    4: return int'(ev_b);   5: return int'(bus_b.ready);
        6: return expq_b.size(); 7: return int'(we_b);   8: return int'(addr_b);
        9: return int'(wd_b);    default: return -1;
      endcase
    end
  endfunction

  function automatic int img_get(int sel, int a);
    if (sel == 0) return img_a.exists(a) ? int'(img_a[a]) : -1;
    else          return img_b.exists(a) ? int'(img_b[a]) : -1;
  endfunction

  function automatic bq_t s2q(string str);
    bq_t q;
    for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
    return q;
  endfunction

  task automatic drive(int sel, logic v, logic [7:0] d, logic l);
    if (sel == 0) begin bus_a.valid = v; bus_a.data = d; bus_a.last = l; end
    else          begin bus_b.valid = v; bus_b.data = d; bus_b.last = l; end
  endtask

  // Expected image as a flat list of writes, computed from the byte rules.
  task automatic model(input bq_t s, input int depth, input bit fin, output wr_t w[$],
                       output int lc, output int eo, output int ec, output int ev, output int lat);
    int  wp, len, b;
    wr_t e;
    wp = 0; len = 0; lc = 0; eo = 0; ec = 0; ev = 0; lat = 2; w.delete();
    foreach (s[i]) begin
      b = int'(s[i]);
      if ((b >= 97 && b <= 122) || (b >= 65 && b <= 90)) begin
        if (wp <= depth - 3) begin
          e.addr = wp; e.data = (b >= 97) ? b - 96 : b - 38;
          w.push_back(e); wp++; len++;
        end else ev = 1;
      end else if (b == 10) begin
        if (len > 0) begin
          if (wp <= depth - 2) begin e.addr = wp; e.data = 0; w.push_back(e); wp++; end
          if (lc < 65535) lc++;
          if (len % 2 == 1) eo = 1;
          len = 0;
        end
      end else if (b != 13) ec = 1;
    end
    if (fin) begin
      if (len > 0) begin
        if (wp <= depth - 2) begin e.addr = wp; e.data = 0; w.push_back(e); wp++; end
        if (lc < 65535) lc++;
        if (len % 2 == 1) eo = 1;
        lat = 3;
      end
      e.addr = wp; e.data = 0; w.push_back(e);
    end
  endtask

  task automatic send(int sel, logic [7:0] b, logic l, int gap);
    int t;
    repeat (gap) begin @(negedge clk); drive(sel, 1'b0, 8'h00, 1'b0); end
    @(negedge clk);
    drive(sel, 1'b1, b, l);
    t = 0;
    while (st(sel, 5) == 0 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_we", st(s, 7), 0);       chk("rst_addr", st(s, 8), 0);
      chk("rst_wdata", st(s, 9), 0);    chk("rst_done", st(s, 0), 0);
      chk("rst_lc", st(s, 1), 0);       chk("rst_eo", st(s, 2), 0);
      chk("rst_ec", st(s, 3), 0);       chk("rst_ev", st(s, 4), 0);
      chk("rst_ready_low", st(s, 5), 0);
    end
    rst = 1'b0;
    #1;
    chk("ready_after_rst_a", st(0, 5), 1);
    chk("ready_after_rst_b", st(1, 5), 1);
    img_a.delete();
    img_b.delete();
  endtask

  task automatic run(int sel, bq_t s, int maxgap);
    wr_t w[$];
    int  lc, eo, ec, ev, lat, gap;
    model(s, (sel == 0) ? 16384 : 8, 1'b1, w, lc, eo, ec, ev, lat);
    foreach (w[i]) if (sel == 0) expq_a.push_back(w[i]); else expq_b.push_back(w[i]);
    foreach (s[i]) begin
      gap = (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
      send(sel, s[i], (i == s.size() - 1), gap);
    end
    // Keep offering a byte after the end: it must be refused and never written.
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      drive(sel, 1'b1, 8'h61, 1'b0);
      chk("ready_low_after_last", st(sel, 5), 0);
      chk("done_timing", st(sel, 0), (k == lat) ? 1 : 0);
    end
    repeat (3) begin @(negedge clk); chk("ready_low_in_done", st(sel, 5), 0); end
    drive(sel, 1'b0, 8'h00, 1'b0);
    chk("writes_outstanding", st(sel, 6), 0);
    chk("line_count", st(sel, 1), lc);
    chk("err_odd", st(sel, 2), eo);
    chk("err_char", st(sel, 3), ec);
    chk("err_overflow", st(sel, 4), ev);
    chk("done_sticky", st(sel, 0), 1);
  endtask

  task automatic check_img(int sel, string tag, bq_t exp);
    foreach (exp[i]) chk($sformatf("%s_img%0d", tag, i), img_get(sel, i), int'(exp[i]));
  endtask

  bq_t s, t, e;
  wr_t wq[$];
  int  m_lc, m_eo, m_ec, m_ev, m_lat, n, r;
  logic [7:0] others[7] = '{8'h23, 8'h30, 8'h7B, 8'h40, 8'h5B, 8'h60, 8'h00};

  initial begin
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    do_reset();

    s = s2q("abAB\n");
    run(0, s, 0);
    e = '{8'd1, 8'd2, 8'd27, 8'd28, 8'd0, 8'd0};
    check_img(0, "t1", e);
    chk("t1_lc_literal", int'(lc_a), 1);

    do_reset();
    s = s2q("aZ");
    run(0, s, 0);
    e = '{8'd1, 8'd52, 8'd0, 8'd0};
    check_img(0, "t2", e);

    do_reset();
    s = s2q("ab\n");
    s.push_back(8'h0D);
    t = s2q("\n\ncd");
    foreach (t[i]) s.push_back(t[i]);
    run(0, s, 3);
    e = '{8'd1, 8'd2, 8'd0, 8'd3, 8'd4, 8'd0, 8'd0};
    check_img(0, "t3", e);
    chk("t3_lc_literal", int'(lc_a), 2);

    do_reset();
    s = s2q("abc\n#\n");
    run(0, s, 0);
    e = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0};
    check_img(0, "t4", e);
    chk("t4_err_odd_literal", int'(eo_a), 1);
    chk("t4_err_char_literal", int'(ec_a), 1);

    do_reset();
    s = s2q("aaaaaaaaaa\n");
    run(1, s, 0);
    e = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};
    check_img(1, "t5", e);
    chk("t5_overflow_literal", int'(ev_b), 1);

    do_reset();
    s = s2q("\n");
    run(0, s, 0);
    e = '{8'd0};
    check_img(0, "empty", e);
    chk("empty_lc_literal", int'(lc_a), 0);

    // Reset mid-stream: only the two letters already accepted get written.
    do_reset();
    s = s2q("ab");
    model(s, 16384, 1'b0, wq, m_lc, m_eo, m_ec, m_ev, m_lat);
    foreach (wq[i]) expq_a.push_back(wq[i]);
    send(0, 8'h61, 1'b0, 0);
    send(0, 8'h62, 1'b0, 0);
    do_reset();
    chk("midrst_drained", expq_a.size(), 0);
    s = s2q("cd\n");
    run(0, s, 0);
    e = '{8'd3, 8'd4, 8'd0, 8'd0};
    check_img(0, "t6", e);
    chk("t6_lc_literal", int'(lc_a), 1);

    for (int k = 0; k < 8; k++) begin
      do_reset();
      s.delete();
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) begin
        r = int'($urandom_range(0, 19));
        if (r < 8)       s.push_back(8'(8'h61 + $urandom_range(0, 25)));
        else if (r < 14) s.push_back(8'(8'h41 + $urandom_range(0, 25)));
        else if (r < 17) s.push_back(8'h0A);
        else if (r < 18) s.push_back(8'h0D);
        else             s.push_back(others[$urandom_range(0, 6)]);
      end
      run(k % 2, s, (k < 4) ? 0 : 3);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/rucksack_rom_loader.md
Name: rucksack_rom_loader

Overview:
- Writer side of the day-3 rucksack memory image. Accepts a raw ASCII puzzle-input byte stream over a valid/ready handshake.
- Converts each item letter to its priority code and writes the codes into a single-port write interface of the distributed item memory.
- Memory format: each line is terminated by one 0x00. The image ends with an additional 0x00, so the last line is followed by two consecutive zeros. This is exactly the layout the part-1/part-2 solvers scan.

Parameters:
- ADDR_W, 14, memory address width; depth = 2**ADDR_W.
- DATA_W, 8, memory data width; priority codes occupy bits [5:0], upper bits are zero.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data/in_last valid.
- in_data  in  8  ASCII input byte.
- in_last  in  1  marks final byte of the input file.
- in_ready  out  1  block accepts a byte this cycle; transfer occurs when in_valid && in_ready.
- mem_we  out  1  write strobe, one-cycle pulse per write.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- done  out  1  image complete; sticky until rst.
- line_count  out  16  number of non-empty lines written; saturates at 0xFFFF.
- err_odd  out  1  sticky: some line had an odd item count.
- err_char  out  1  sticky: an unsupported byte was received.
- err_overflow  out  1  sticky: letters dropped because memory was full.

Behaviour:
- Reset values:
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - done=0, line_count=0, all err_*=0.
  - Internal write pointer wptr=0, line length len=0.
  - state=LOAD.
  - Memory contents are not cleared.
- in_ready = (state==LOAD) && !rst, combinational.
- Write port is fully registered. A byte accepted in cycle N produces its write, if any, with mem_we=1 in cycle N+1 at mem_addr=wptr. wptr increments after each write. mem_we=0 in all other cycles; mem_addr/mem_wdata hold their last values.
- Byte mapping on acceptance:
  - 'a'..'z' (0x61-0x7A): write 1..26 (in_data-0x60), len++.
  - 'A'..'Z' (0x41-0x5A): write 27..52 (in_data-0x26), len++.
  - 0x0A with len>0: write 0x00, line_count++, set err_odd if len[0]=1, then len=0.
  - 0x0A with len==0: empty line, no write.
  - 0x0D: ignored, no write, no error.
  - Any other byte: ignored, set err_char.
- Capacity rules, which keep room for the terminators:
  - A letter is written only if wptr <= DEPTH-3. Otherwise it is dropped, err_overflow is set, and len is unchanged.
  - A line-end zero is written only if wptr <= DEPTH-2.
  - The final zero always fits.
- States:
  - LOAD: accepting bytes. If the accepted byte has in_last=1 → FLUSH_LINE if len>0 after processing that byte, else FLUSH_END.
  - FLUSH_LINE: in_ready=0. Issues a line-end zero one cycle after the last byte's write slot, with the same line_count/err_odd updates and capacity rule → FLUSH_END.
  - FLUSH_END: in_ready=0. Issues the final 0x00 write → DONE.
  - DONE: done=1 from the cycle after the final mem_we pulse. in_ready=0, input ignored, no writes. Exit only via rst.
- Latency:
  - One write per cycle maximum; the block never stalls inside LOAD.
  - From the accepted last byte, done rises at N+3 if the last line is unterminated, else at N+2.
- in_valid gaps: no effect on state. Back-to-back transfers are supported at full rate.
- Reset mid-operation: rst in any state returns everything to reset values on that edge. Subsequent input writes from address 0.
- An empty input (first byte is 0x0A with in_last) produces a single 0x00 at address 0, with line_count=0.

Test Plan:
- "abAB\n" back-to-back, in_last on '\n' → writes addr0..5 = 1,2,27,28,0,0; line_count=1; done high 2 cycles after last transfer; no errors.
- "aZ", in_last on 'Z' → writes addr0..3 = 1,52,0,0; in_ready low for 2 cycles after last transfer; done then high; line_count=1.
- "ab\n\r\n\ncd", in_last on 'd', with random in_valid gaps → writes 1,2,0,3,4,0,0 at addr0..6; line_count=2; err_char=0; exactly 7 mem_we pulses.
- "abc\n#\n", in_last on final '\n' → writes 1,2,3,0,0; err_odd=1; err_char=1; line_count=1.
- ADDR_W=3 (depth 8): ten 'a' then '\n' with in_last → addr0..5 = 1; 4 letters dropped; err_overflow=1; addr6=0; addr7=0; done=1.
- Send "ab", assert rst for 1 cycle mid-stream, then "cd\n" with in_last → all outputs at reset values after the rst edge; writes 3,4,0,0 at addr0..3; line_count=1.
